// File: rtl/fifo_packer_if.sv
// Packer bus: upstream FIFO read port, flush pulse and packed output handshake.
// master = packer side, slave = FIFO/downstream side.
// Parameters must match the fifo_packer instance that binds to it.
interface fifo_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int COUNT_W    = $clog2(PACK_RATIO + 1)
);
  logic                           rd_en;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           rd_val;
  logic                           flush;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [COUNT_W-1:0]             out_count;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_val,
    input  flush,
    output out_data,
    output out_count,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_val,
    output flush,
    input  out_data,
    input  out_count,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_packer.sv
// Packs PACK_RATIO consecutive FIFO words into one wide word (lane 0 = first word).
// Latency: packed word valid the cycle after the last lane's rd_val; flush emits a partial word.
// Backpressure: output held until out_ready; reads stop once the accumulator plus in-flight read is full.
module fifo_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int COUNT_W    = $clog2(PACK_RATIO + 1)
) (
  input  logic          clk,
  input  logic          reset,
  fifo_packer_if.master bus
);
  localparam int                 OUT_W    = DATA_WIDTH * PACK_RATIO;
  localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(PACK_RATIO);
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(PACK_RATIO - 1);

  // Lanes 0..PACK_RATIO-2 wait in acc; the final word either goes straight
  // to the output register or parks in last_q while the output is blocked.
  logic [PACK_RATIO-2:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]                 last_q, last_d;
  logic [COUNT_W-1:0]                    cnt_q, cnt_d;
  logic                                  pending_q;
  logic                                  flush_req_q, flush_req_d;
  logic [OUT_W-1:0]                      out_data_q, out_data_d;
  logic [COUNT_W-1:0]                    out_count_q, out_count_d;
  logic                                  out_valid_q, out_valid_d;

  logic             rd_en;
  logic             out_free;
  logic             capture;
  logic [OUT_W-1:0] flush_word;

  // Issue a read only while the in-flight read still fits into the word being built.
  always_comb begin
    rd_en = !reset && !flush_req_q &&
            (({1'b0, cnt_q} + {{COUNT_W{1'b0}}, pending_q}) < {1'b0, CNT_FULL});
  end

  assign out_free = !out_valid_q || bus.out_ready;
  // rd_val only means something when we actually have a read outstanding.
  assign capture  = pending_q && bus.rd_val;

  // Partial word for flush: filled lanes copied, the rest forced to zero.
  always_comb begin
    flush_word = '0;
    for (int k = 0; k < PACK_RATIO - 1; k++) begin
      if (COUNT_W'(k) < cnt_q) flush_word[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
    end
  end

  // Next state: capture has priority, then a parked full word, then a flush.
  always_comb begin
    acc_d       = acc_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    flush_req_d = flush_req_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    if (capture) begin
      if (cnt_q == CNT_LAST) begin
        if (out_free) begin
          out_data_d  = {bus.rd_data, acc_q};
          out_count_d = CNT_FULL;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          last_d = bus.rd_data;
          cnt_d  = CNT_FULL;
        end
      end else begin
        for (int k = 0; k < PACK_RATIO - 1; k++) begin
          if (COUNT_W'(k) == cnt_q) acc_d[k] = bus.rd_data;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q == CNT_FULL) begin
      // A full word is always complete, so it also satisfies any pending flush.
      if (out_free) begin
        out_data_d  = {last_q, acc_q};
        out_count_d = CNT_FULL;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        flush_req_d = 1'b0;
      end
    end else if (flush_req_q && !pending_q) begin
      if (cnt_q == '0) begin
        flush_req_d = 1'b0;
      end else if (out_free) begin
        out_data_d  = flush_word;
        out_count_d = cnt_q;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        flush_req_d = 1'b0;
      end
    end

    // A second flush while one is outstanding folds into the same request.
    if (bus.flush && !flush_req_q) flush_req_d = 1'b1;
  end

  // State registers with synchronous reset; reset drops accumulated lanes and the in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      flush_req_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      pending_q   <= rd_en;
      flush_req_q <= flush_req_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer (DATA_WIDTH=8, PACK_RATIO=4) with a 1-cycle-latency FIFO model.
// Expected packed words are queued as stimulus is driven and checked on each output handshake.
// Output hold stability and rd_en behaviour under reset are checked every cycle.
module tb_fifo_packer;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  fifo_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4)) bus ();

  fifo_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [7:0]  fifo_q[$];
  bit          starve = 1'b0;
  int          cyc = 0;
  int          last_rv_cyc = -1;
  int          last_ov_cyc = -1;
  int          ov_count = 0;
  bit          hold_vld = 1'b0;
  logic [31:0] held_data;
  logic [2:0]  held_cnt;

  // One clock cycle: sample outputs at negedge, then drive the FIFO model after the edge.
  task automatic cycle();
    logic en;
    exp_t e;
    @(negedge clk);
    en = bus.rd_en;
    if (reset) begin
      n_cmp++;
      if (bus.rd_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_en_in_reset: got %b want 0", bus.rd_en);
      end
    end
    if (hold_vld) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held_data || bus.out_count !== held_cnt) begin
        n_bad++;
        $display("FAIL hold_stable: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                 bus.out_valid, bus.out_data, bus.out_count, held_data, held_cnt);
      end
    end
    hold_vld  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0) && !reset;
    held_data = bus.out_data;
    held_cnt  = bus.out_count;
    if (bus.rd_val === 1'b1) last_rv_cyc = cyc;
    if (bus.out_valid === 1'b1) begin
      last_ov_cyc = cyc;
      ov_count++;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got d=%h c=%0d want none", bus.out_data, bus.out_count);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.out_data !== e.data) begin
          n_bad++;
          $display("FAIL out_data: got %h want %h", bus.out_data, e.data);
        end
        n_cmp++;
        if (bus.out_count !== e.cnt) begin
          n_bad++;
          $display("FAIL out_count: got %0d want %0d", bus.out_count, e.cnt);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.flush = 1'b0;
    if (en && !starve && fifo_q.size() > 0) begin
      bus.rd_val  = 1'b1;
      bus.rd_data = fifo_q.pop_front();
    end else begin
      bus.rd_val  = 1'b0;
      bus.rd_data = 8'($urandom);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && sb.size() > 0; i++) cycle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d words outstanding want 0", name, sb.size());
      sb.delete();
    end
    repeat (3) cycle();
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
    fifo_q.push_back(d);
    sb.push_back('{data: {d, c, b, a}, cnt: 3'd4});
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.rd_val    = 1'b0;
    bus.rd_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++;
    if (bus.out_count !== 3'd0) begin n_bad++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
    n_cmp++;
    if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    reset = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_basic();
    ov_count    = 0;
    last_rv_cyc = -1;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    drain("basic");
    n_cmp++;
    if (ov_count != 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", ov_count); end
    n_cmp++;
    if (last_ov_cyc != last_rv_cyc + 1) begin
      n_bad++;
      $display("FAIL basic_latency: got out cycle %0d want %0d", last_ov_cyc, last_rv_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    repeat (14) cycle();
    n_cmp++;
    if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL bp_rd_en_stall: got %b want 0", bus.rd_en); end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
      n_bad++;
      $display("FAIL bp_first_held: got v=%b d=%h want v=1 d=44332211", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_flush();
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    repeat (6) cycle();
    bus.flush = 1'b1;
    sb.push_back('{data: 32'h0000A2A1, cnt: 3'd2});
    drain("flush");
    // Count must be back at zero: next four words form a complete word.
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    drain("after_flush");
  endtask

  task automatic test_flush_inflight();
    fifo_q.push_back(8'hB1);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hB3);
    repeat (3) cycle();
    // B3 is on rd_val in this cycle; it has to land before the flush.
    bus.flush = 1'b1;
    sb.push_back('{data: 32'h00B3B2B1, cnt: 3'd3});
    drain("flush_inflight");
  endtask

  task automatic test_empty();
    starve = 1'b1;
    push4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    repeat (5) cycle();
    starve = 1'b0;
    drain("empty");
  endtask

  task automatic test_flush_empty();
    ov_count  = 0;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b1;
    repeat (5) cycle();
    n_cmp++;
    if (ov_count != 0) begin n_bad++; $display("FAIL flush_empty_no_word: got %0d valid cycles want 0", ov_count); end
    n_cmp++;
    if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL flush_empty_rd_en: got %b want 1", bus.rd_en); end
  endtask

  task automatic test_reset_mid();
    fifo_q.push_back(8'hD1);
    fifo_q.push_back(8'hD2);
    fifo_q.push_back(8'hD3);
    repeat (6) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid); end
    reset = 1'b0;
    push4(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[12];
    for (int i = 0; i < 12; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) push4(w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]);
    for (int i = 0; i < 400 && sb.size() > 0; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.out_ready = 1'b1;
    drain("back_to_back");
  endtask

  initial begin
    reset         = 1'b1;
    bus.rd_val    = 1'b0;
    bus.rd_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_inflight();
    test_empty();
    test_flush_empty();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one FIFO word.
REQ-002 Parameter PACK_RATIO, default 4, FIFO words per output word (>=2).
REQ-003 Parameter COUNT_W, default $clog2(PACK_RATIO+1), width of word counters.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rd_en  output  1  read request to upstream fifo rd_en.
REQ-007 rd_data  input  DATA_WIDTH  upstream fifo read word, valid when rd_val=1.
REQ-008 rd_val  input  1  upstream fifo read-valid, one cycle after an accepted rd_en.
REQ-009 flush  input  1  single-cycle pulse: emit partially filled word.
REQ-010 out_data  output  DATA_WIDTH*PACK_RATIO  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 out_count  output  COUNT_W  number of valid lanes in out_data (1..PACK_RATIO).
REQ-012 out_valid  output  1  out_data/out_count valid.
REQ-013 out_ready  input  1  downstream accepts word when out_valid & out_ready.

Function
REQ-014 Internal state: accumulator acc (PACK_RATIO-1 lanes), fill count cnt, pending flag, flush_req flag, output register.
REQ-015 pending SHALL equal rd_en of the previous cycle (one read in flight max).
REQ-016 rd_en SHALL be 1 iff not reset, flush_req=0, and cnt + pending < PACK_RATIO - (output register blocked ? 0 : 0) i.e. cnt + pending < PACK_RATIO.
REQ-017 A word SHALL be captured only when rd_val=1 and pending=1; rd_val without pending SHALL be ignored.
REQ-018 pending=1 with rd_val=0 (fifo empty) SHALL drop the request silently; rd_en re-evaluated next cycle.
REQ-019 First captured word SHALL occupy lane 0, subsequent words ascending lanes.
REQ-020 Output register "free" SHALL mean out_valid=0 or out_ready=1 in that cycle.
REQ-021 Capture with cnt=PACK_RATIO-1 and output free: load output with {rd_data, acc}, out_count=PACK_RATIO, out_valid=1 next cycle, cnt<=0 (zero-bubble).
REQ-022 Capture with cnt=PACK_RATIO-1 and output not free: store word, cnt<=PACK_RATIO, rd_en held 0; transfer on first cycle output is free, then cnt<=0.
REQ-023 out_valid SHALL stay 1 with out_data/out_count stable until out_ready=1; cleared next cycle unless reloaded same cycle.
REQ-024 flush pulse SHALL set flush_req; flush during flush_req SHALL be absorbed.
REQ-025 With flush_req=1, pending=0 and cnt>0: when output free, load acc lanes 0..cnt-1, unused lanes zero, out_count=cnt, cnt<=0, flush_req<=0.
REQ-026 With flush_req=1, pending=0, cnt=0: clear flush_req, no output word.
REQ-027 A word arriving on the flush cycle's pending read SHALL be captured before flushing.
REQ-028 No word SHALL be lost or duplicated under any out_ready pattern.

Reset
REQ-029 reset SHALL force next cycle: out_valid=0, out_count=0, out_data=0, cnt=0, pending=0, flush_req=0.
REQ-030 rd_en SHALL be 0 during any cycle reset=1.
REQ-031 Reset mid-operation SHALL discard accumulated lanes and any in-flight read; rd_val in the cycle after reset ignored.

Structure
REQ-032 No shared package; COUNT_W and lane width derived locally from parameters.
REQ-033 Single flat module, no sub-modules; combinational rd_en, all else registered.

Verification (DATA_WIDTH=8, PACK_RATIO=4, fifo model with 1-cycle rd_val)
REQ-034 Feed 0x11,0x22,0x33,0x44, out_ready=1 -> out_data=0x44332211, out_count=4, one out_valid cycle, cycle after 4th rd_val.
REQ-035 Feed 8 words, out_ready=0 for 10 cycles -> first word held stable, rd_en=0 once cnt=4, second word 0x88776655 follows without loss.
REQ-036 Feed 0xA1,0xA2 then flush -> out_data=0x0000A2A1, out_count=2, cnt returns 0.
REQ-037 Fifo empty (rd_val=0 after rd_en) for 5 cycles, then 4 words -> only real words packed, out_count=4.
REQ-038 Assert reset after 3 captured words -> out_valid=0, next 4 words form a fresh 4-lane word.
REQ-039 flush with cnt=0, no pending -> no out_valid, flush_req clears in one cycle.
